// File: rtl/trng_cu_gen2.sv
// trng_cu_gen2 -- second-generation TRNG control unit.
// Sequences the entropy datapath through BIST, harvesting and word delivery,
// counts consecutive health-test failures and locks out in DEAD once the
// retry budget is used up.
// Optional build macro: TRNG_CU_WORD_CNT_EN enables the delivered-word
// counter on words_o; without it words_o is tied to zero.
module trng_cu_gen2 #(
  parameter int unsigned BIST_CYCLES    = 10,
  parameter int unsigned HARVEST_CYCLES = 511,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned INTR_PULSE     = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               error_i,
  input  logic                               ack_read_i,
  input  logic                               total_failure_i,
  output logic                               enable_dp_o,
  output logic                               dff_en_o,
  output logic                               flush_regs_o,
  output logic                               rnd_ready_o,
  output logic                               trng_intr_o,
  output logic                               dead_o,
  output logic [2:0]                         state_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
  output logic [31:0]                        words_o
);

  localparam int unsigned CNT_MAX = (BIST_CYCLES > HARVEST_CYCLES) ? BIST_CYCLES : HARVEST_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] BIST_LAST = CNT_W'(BIST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HARV_LAST = CNT_W'(HARVEST_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BIST    = 3'd1,
    S_HARVEST = 3'd2,
    S_READY   = 3'd3,
    S_DEAD    = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_retry;
  logic             r_first;
  logic             w_retry_last;
  logic             w_active;

  // One more error from here would exhaust the retry budget.
  assign w_retry_last = (r_retry >= RTY_LAST);
  assign w_active     = (r_state == S_BIST) || (r_state == S_HARVEST) || (r_state == S_READY);

  // Main sequencer: priority total_failure > disable > error > ack > terminal count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
      r_first <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state <= S_BIST;
            r_cnt   <= '0;
            r_retry <= '0;
          end
        end
        S_BIST, S_HARVEST, S_READY: begin
          if (total_failure_i) begin
            r_state <= S_DEAD;
            r_cnt   <= '0;
          end else if (!enable_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (error_i) begin
            r_cnt <= '0;
            if (w_retry_last) begin
              r_state <= S_DEAD;
              r_retry <= RTY_MAX;
            end else begin
              r_state <= S_BIST;
              r_retry <= r_retry + 1'b1;
            end
          end else if (ack_read_i && (r_state == S_READY)) begin
            r_state <= S_HARVEST;
            r_cnt   <= '0;
            r_retry <= '0;
          end else if ((r_state == S_BIST) && (r_cnt == BIST_LAST)) begin
            r_state <= S_HARVEST;
            r_cnt   <= '0;
          end else if ((r_state == S_HARVEST) && (r_cnt == HARV_LAST)) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end else if (r_state != S_READY) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DEAD: begin
          r_state <= S_DEAD;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state; flush alone sees live inputs.
  always_comb begin
    enable_dp_o  = 1'b0;
    dff_en_o     = 1'b0;
    flush_regs_o = 1'b0;
    rnd_ready_o  = 1'b0;
    trng_intr_o  = 1'b0;
    dead_o       = 1'b0;
    case (r_state)
      S_BIST: begin
        enable_dp_o  = 1'b1;
        dff_en_o     = 1'b1;
        flush_regs_o = 1'b1;
      end
      S_HARVEST: begin
        enable_dp_o  = 1'b1;
        dff_en_o     = 1'b1;
        flush_regs_o = ack_read_i | ~enable_i;
      end
      S_READY: begin
        enable_dp_o  = 1'b1;
        dff_en_o     = 1'b1;
        rnd_ready_o  = 1'b1;
        flush_regs_o = ack_read_i | error_i | ~enable_i;
        trng_intr_o  = (INTR_PULSE != 0) ? r_first : 1'b1;
      end
      S_DEAD: begin
        flush_regs_o = 1'b1;
        dead_o       = 1'b1;
        trng_intr_o  = 1'b1;
      end
      default: begin
        enable_dp_o = 1'b0;
      end
    endcase
    if (!w_active && (r_state != S_DEAD)) begin
      flush_regs_o = 1'b0;
    end
  end

  assign state_o     = r_state;
  assign retry_cnt_o = r_retry;

`ifdef TRNG_CU_WORD_CNT_EN
  logic [31:0] r_words;
  logic        w_word_accept;

  // An ack only counts when it actually wins arbitration in READY.
  assign w_word_accept = (r_state == S_READY) && !total_failure_i && enable_i &&
                         !error_i && ack_read_i;

  // Saturating delivered-word counter, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_words <= '0;
    end else if (w_word_accept && (r_words != '1)) begin
      r_words <= r_words + 1'b1;
    end
  end

  assign words_o = r_words;
`else
  assign words_o = '0;
`endif

endmodule

// File: tb/tb_trng_cu_gen2.sv
// Bench for trng_cu_gen2: two instances (default and a short pulsed-interrupt
// configuration) driven with the same directed and random stimulus and
// compared each cycle against a countdown-based reference model.
module tb_trng_cu_gen2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic err = 1'b0;
  logic ack = 1'b0;
  logic tf  = 1'b0;

  logic        a_edp, a_dff, a_flush, a_rdy, a_intr, a_dead;
  logic [2:0]  a_state;
  logic [2:0]  a_retry;
  logic [31:0] a_words;

  logic        b_edp, b_dff, b_flush, b_rdy, b_intr, b_dead;
  logic [2:0]  b_state;
  logic [1:0]  b_retry;
  logic [31:0] b_words;

  always #5 clk = ~clk;

  trng_cu_gen2 u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_i(err), .ack_read_i(ack),
    .total_failure_i(tf), .enable_dp_o(a_edp), .dff_en_o(a_dff),
    .flush_regs_o(a_flush), .rnd_ready_o(a_rdy), .trng_intr_o(a_intr),
    .dead_o(a_dead), .state_o(a_state), .retry_cnt_o(a_retry), .words_o(a_words)
  );

  trng_cu_gen2 #(
    .BIST_CYCLES(3), .HARVEST_CYCLES(5), .MAX_RETRIES(2), .INTR_PULSE(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_i(err), .ack_read_i(ack),
    .total_failure_i(tf), .enable_dp_o(b_edp), .dff_en_o(b_dff),
    .flush_regs_o(b_flush), .rnd_ready_o(b_rdy), .trng_intr_o(b_intr),
    .dead_o(b_dead), .state_o(b_state), .retry_cnt_o(b_retry), .words_o(b_words)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // st: 0 idle, 1 bist, 2 harvest, 3 ready, 4 dead; left = cycles still owed in state
  typedef struct {
    int              st;
    int              left;
    int              retry;
    bit              first;
    longint unsigned words;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.left = 0; m.retry = 0; m.first = 1'b0; m.words = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int bist, int harv, int maxr,
                                    bit e, bit er, bit ak, bit t);
    mdl_t n;
    n = m;
    if (m.st == 0) begin
      if (e) begin n.st = 1; n.left = bist; n.retry = 0; end
    end else if (m.st != 4) begin
      if (t) n.st = 4;
      else if (!e) n.st = 0;
      else if (er) begin
        if (m.retry + 1 >= maxr) begin n.st = 4; n.retry = maxr; end
        else begin n.st = 1; n.left = bist; n.retry = m.retry + 1; end
      end else if (m.st == 3) begin
        if (ak) begin
          n.st = 2; n.left = harv; n.retry = 0;
          if (m.words != 64'hFFFF_FFFF) n.words = m.words + 1;
        end
      end else begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          if (m.st == 1) begin n.st = 2; n.left = harv; end
          else n.st = 3;
        end
      end
    end
    n.first = (n.st == 3) && (m.st != 3);
    return n;
  endfunction

  function automatic bit exp_flush(mdl_t m, bit e, bit er, bit ak);
    case (m.st)
      1, 4:    return 1'b1;
      2:       return ak || !e;
      3:       return ak || er || !e;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string p, mdl_t m, bit pulse, logic [2:0] st,
                           logic [31:0] rty, logic edp, logic dff, logic rdy,
                           logic intr, logic dead, logic [31:0] w);
    bit act;
    bit ei;
    act = (m.st >= 1) && (m.st <= 3);
    ei  = (m.st == 4) || ((m.st == 3) && (pulse ? m.first : 1'b1));
    chk({p, ".state"}, 32'(st), 32'(m.st));
    chk({p, ".retry"}, rty, 32'(m.retry));
    chk({p, ".enable_dp"}, 32'(edp), 32'(act));
    chk({p, ".dff_en"}, 32'(dff), 32'(act));
    chk({p, ".rnd_ready"}, 32'(rdy), 32'(m.st == 3));
    chk({p, ".intr"}, 32'(intr), 32'(ei));
    chk({p, ".dead"}, 32'(dead), 32'(m.st == 4));
`ifdef TRNG_CU_WORD_CNT_EN
    chk({p, ".words"}, w, 32'(m.words));
`else
    chk({p, ".words"}, w, 32'd0);
`endif
  endtask

  task automatic check_both();
    check_out("A", ma, 1'b0, a_state, 32'(a_retry), a_edp, a_dff, a_rdy, a_intr, a_dead, a_words);
    check_out("B", mb, 1'b1, b_state, 32'(b_retry), b_edp, b_dff, b_rdy, b_intr, b_dead, b_words);
  endtask

  task automatic step(bit e, bit er, bit ak, bit t);
    en = e; err = er; ack = ak; tf = t;
    #2;
    chk("A.flush", 32'(a_flush), 32'(exp_flush(ma, e, er, ak)));
    chk("B.flush", 32'(b_flush), 32'(exp_flush(mb, e, er, ak)));
    @(posedge clk);
    ma = mdl_next(ma, 10, 511, 4, e, er, ak, t);
    mb = mdl_next(mb, 3, 5, 2, e, er, ak, t);
    #1;
    check_both();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_both();
    chk("A.flush_rst", 32'(a_flush), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int dead_run;
    ma = mdl_reset();
    mb = mdl_reset();
    rst = 1'b1;
    #12;
    check_both();
    rst = 1'b0;

    // Power-up: enable sampled at edge 0
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp.bist_entry", 32'(a_state), 32'd1);
    run(10);
    chk("tp.harvest_entry", 32'(a_state), 32'd2);
    run(511);
    chk("tp.ready_entry", 32'(a_state), 32'd3);
    chk("tp.ready_rdy", 32'(a_rdy), 32'd1);
    chk("tp.ready_intr", 32'(a_intr), 32'd1);

    // Single ack in READY, then a full harvest back to READY
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tp.ack_rdy_drop", 32'(a_rdy), 32'd0);
    run(510);
    chk("tp.ack_still_harv", 32'(a_state), 32'd2);
    run(1);
    chk("tp.ack_ready_again", 32'(a_state), 32'd3);
    chk("tp.ack_retry0", 32'(a_retry), 32'd0);

    // Error and ack together in READY: error wins
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("tp.err_ack_state", 32'(a_state), 32'd1);
    chk("tp.err_ack_retry", 32'(a_retry), 32'd1);

    // Error at BIST counter 5
    run(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp.bist_err_retry", 32'(a_retry), 32'd2);
    run(9);
    chk("tp.bist_err_hold", 32'(a_state), 32'd1);
    run(1);
    chk("tp.bist_err_harv", 32'(a_state), 32'd2);

    // total_failure in HARVEST, then DEAD holds while enable toggles
    run(20);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("tp.tf_dead", 32'(a_state), 32'd4);
    for (int i = 0; i < 100; i++) step(1'(i % 2), 1'(i % 3 == 0), 1'(i % 5 == 0), 1'b0);
    chk("tp.dead_hold", 32'(a_dead), 32'd1);
    do_reset();
    chk("tp.reset_idle", 32'(a_state), 32'd0);

    // total_failure ignored in IDLE
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp.tf_idle", 32'(a_state), 32'd0);

    // Four consecutive BIST errors -> DEAD
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp.err3_bist", 32'(a_state), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp.err4_dead", 32'(a_state), 32'd4);
    chk("tp.err4_edp", 32'(a_edp), 32'd0);
    chk("tp.err4_flush", 32'(a_flush), 32'd1);
    chk("tp.err4_retry", 32'(a_retry), 32'd4);
    do_reset();

    // Disable mid-HARVEST
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(15);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp.disable_idle", 32'(a_state), 32'd0);

    // Random phase
    dead_run = 0;
    for (int i = 0; i < 6000; i++) begin
      step(1'($urandom_range(0, 99) < 97), 1'($urandom_range(0, 999) < 4),
           1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 1999) < 1));
      dead_run = (mb.st == 4 || ma.st == 4) ? dead_run + 1 : 0;
      if (dead_run > 25) begin
        do_reset();
        dead_run = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
